ladybird_irq_controller: RTL and testbench
==========================================

# ladybird_irq_controller

Parametrised interrupt controller that replaces the single OR-reduced `pending` line between the peripherals and `ladybird_core`. It collects `N_SOURCES` interrupt requests and applies a per-source enable, a per-source priority and a global threshold. It drives one `irq` line to the core and provides claim/complete handshaking through a word-addressed register port. Sources can be level- or edge-sensitive when that feature is compiled in.

## Interface
- `N_SOURCES`, 8: number of interrupt sources, 1..31. Source IDs are 1..N_SOURCES; ID 0 means "none".
- `PRIO_W`, 3: priority width. Priority 0 means the source never interrupts.
- `ADDR_W`, 6: register word-address width. Must be at least 6.

Ports:
- `clk` in, 1: the single clock.
- `nrst` in, 1: reset, asynchronous, active-low.
- `src` in, N_SOURCES: interrupt requests, synchronous to `clk`. Bit i is source ID i+1.
- `req` in, 1: register access strobe.
- `we` in, 1: write when 1, read when 0.
- `addr` in, ADDR_W: word address.
- `wdata` in, 32: write data.
- `rvalid` out, 1: read data valid.
- `rdata` out, 32: read data.
- `irq` out, 1: interrupt request to the core.

## Operation
Register map (word address):
- 0x00 PENDING: read-only; bit i = pending[i].
- 0x01 ENABLE: read/write; reset 0.
- 0x02 THRESHOLD: read/write, PRIO_W bits; reset 0.
- 0x03 CLAIM/COMPLETE: a read claims, a write completes.
- 0x04 MODE: read/write; bit i = 1 selects edge mode; reset 0.
- 0x20+i PRIORITY[i]: read/write, PRIO_W bits; reset 0.
- Unmapped reads return 0. Unmapped writes are ignored. Unused upper bits read 0.

Gateway, per source:
- Level mode: pending[i] = registered `src[i]`.
- Edge mode: pending[i] is set on a registered 0→1 transition of `src[i]`. It is cleared when source i is claimed.
- Set and claim in the same cycle: set wins, so the pending bit stays 1.

Arbitration:
- A source is eligible when pending & enable & ~in_service and priority > THRESHOLD.
- The winner is the eligible source with the highest priority. Ties go to the lowest ID.
- `irq` = 1 when any source is eligible.

Claim:
- A read of 0x03 returns the winner ID, or 0 if none is eligible.
- If the ID is nonzero, in_service[ID] is set. An edge-mode source also has its pending bit cleared.
- A claimed source is excluded from arbitration until it is completed.

Complete:
- A write of ID to 0x03 clears in_service[ID].
- The write is ignored when ID is 0, when ID > N_SOURCES, or when ID is not in service.

Other rules:
- Writing ENABLE, PRIORITY or THRESHOLD does not affect in_service.
- Each source can be in service only once; nested claims of different sources are allowed.

## Timing
- All outputs reset to 0: `irq`=0, `rvalid`=0, `rdata`=0. All state resets to 0.
- `src` is registered once before the gateway.
- `irq` is registered. It rises 2 cycles after `src` rises, provided enable and priority are already configured.
- Read latency is 1: `rvalid`=1 with `rdata` in the cycle after `req`&~`we`. Otherwise `rvalid`=0.
- Register writes take effect in the cycle after the `req`.
- The claim winner is the one computed in the cycle the read is requested. in_service updates in the same edge that registers `rdata`.
- After a claim, `irq` reflects the updated state 1 cycle later. Software reading CLAIM back-to-back gets the next winner.
- A complete takes effect at the next edge. A still-pending level source reasserts `irq` 1 cycle later.
- `req` is accepted every cycle; there is no backpressure.
- Asserting `nrst` mid-operation clears pending, in_service and all configuration immediately.

## Configuration
- `LADYBIRD_IRQ_EDGE_EN` defined: MODE register, edge detectors and edge pending flops are present, as described above.
- Undefined: every source is level-sensitive. MODE reads 0 and writes to it are ignored. No edge logic is synthesised.

## Test plan
- Reset: assert `nrst`=0 mid-traffic. Then `irq`=0 and `rvalid`=0, and reads of 0x01, 0x02, 0x04 and 0x20 all return 0.
- Priority/tie:
  - Set up: PRIORITY[2]=5, PRIORITY[4]=5, PRIORITY[1]=3, ENABLE=0x16, raise `src[1]`, `src[2]` and `src[4]`.
  - The first CLAIM returns 3, the second returns 5, the third returns 2, and the fourth returns 0.
- Threshold: THRESHOLD=5 with the priority-5 source pending → `irq`=0 and CLAIM returns 0. THRESHOLD=4 → `irq`=1 two cycles later.
- Complete rules:
  - Claim ID 3 with level `src` still high, then write 7 to 0x03 → no change.
  - Write 3 → `irq` rises again and CLAIM returns 3.
- Edge mode (`LADYBIRD_IRQ_EDGE_EN`): MODE bit 0 set, pulse `src[0]` for 1 cycle → CLAIM returns 1.
  - A second pulse during service sets pending again; after completing 1, CLAIM returns 1 again.
- Latency: `src` rises at cycle t → `irq`=1 at t+2. A CLAIM issued at cycle c → `rvalid`=1 with the ID at c+1.

Source files
------------

// File: rtl/ladybird_irq_controller.sv
// Interrupt controller: per-source enable/priority, global threshold, claim/complete via a word-addressed register port.
// Optional edge-sensitive sources and MODE register when LADYBIRD_IRQ_EDGE_EN is defined.
module ladybird_irq_controller #(
    parameter int unsigned N_SOURCES = 8,
    parameter int unsigned PRIO_W    = 3,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [N_SOURCES-1:0] src,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [31:0]          wdata,
    output logic                 rvalid,
    output logic [31:0]          rdata,
    output logic                 irq
);

    localparam logic [ADDR_W-1:0] A_PENDING   = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_ENABLE    = ADDR_W'(32'h01);
    localparam logic [ADDR_W-1:0] A_THRESHOLD = ADDR_W'(32'h02);
    localparam logic [ADDR_W-1:0] A_CLAIM     = ADDR_W'(32'h03);
    localparam logic [ADDR_W-1:0] A_MODE      = ADDR_W'(32'h04);

    logic [N_SOURCES-1:0] src_q;
    logic [N_SOURCES-1:0] pending;
    logic [N_SOURCES-1:0] enable;
    logic [N_SOURCES-1:0] in_service;
    logic [N_SOURCES-1:0] eligible;
    logic [N_SOURCES-1:0] win_onehot;
    logic [N_SOURCES-1:0] claim_mask;
    logic [N_SOURCES-1:0] complete_mask;
    logic [N_SOURCES-1:0] mode_rd;
    logic [PRIO_W-1:0]    threshold;
    logic [PRIO_W-1:0]    prio [N_SOURCES];
    logic [PRIO_W-1:0]    best_prio;
    logic [4:0]           winner_id;
    logic [31:0]          rd_mux;
    logic                 rd_en;
    logic                 wr_en;
    logic                 claim;

    assign rd_en = req & ~we;
    assign wr_en = req & we;
    assign claim = rd_en && (addr == A_CLAIM);

`ifdef LADYBIRD_IRQ_EDGE_EN
    logic [N_SOURCES-1:0] mode;
    logic [N_SOURCES-1:0] src_qq;
    logic [N_SOURCES-1:0] edge_pend;

    // A new rising edge beats a claim in the same cycle, so the set term is ORed last.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mode      <= '0;
            src_qq    <= '0;
            edge_pend <= '0;
        end else begin
            src_qq    <= src_q;
            edge_pend <= (edge_pend & ~claim_mask) | (src_q & ~src_qq);
            if (wr_en && (addr == A_MODE)) begin
                mode <= wdata[N_SOURCES-1:0];
            end
        end
    end

    assign pending = (mode & edge_pend) | (~mode & src_q);
    assign mode_rd = mode;
`else
    assign pending = src_q;
    assign mode_rd = '0;
`endif

    // Strict '>' keeps the lowest ID on equal priority.
    always_comb begin
        eligible   = '0;
        win_onehot = '0;
        best_prio  = '0;
        winner_id  = '0;
        for (int unsigned i = 0; i < N_SOURCES; i++) begin
            eligible[i] = pending[i] & enable[i] & ~in_service[i] & (prio[i] > threshold);
            if (eligible[i] && (prio[i] > best_prio)) begin
                best_prio     = prio[i];
                winner_id     = 5'(i + 1);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    assign claim_mask = claim ? win_onehot : '0;

    always_comb begin
        complete_mask = '0;
        for (int unsigned i = 0; i < N_SOURCES; i++) begin
            complete_mask[i] = wr_en && (addr == A_CLAIM) && (wdata == 32'(i + 1));
        end
    end

    always_comb begin
        rd_mux = '0;
        if (addr == A_PENDING) begin
            rd_mux[N_SOURCES-1:0] = pending;
        end else if (addr == A_ENABLE) begin
            rd_mux[N_SOURCES-1:0] = enable;
        end else if (addr == A_THRESHOLD) begin
            rd_mux[PRIO_W-1:0] = threshold;
        end else if (addr == A_CLAIM) begin
            rd_mux[4:0] = winner_id;
        end else if (addr == A_MODE) begin
            rd_mux[N_SOURCES-1:0] = mode_rd;
        end else begin
            for (int unsigned i = 0; i < N_SOURCES; i++) begin
                if (addr == ADDR_W'(32 + i)) begin
                    rd_mux[PRIO_W-1:0] = prio[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            src_q      <= '0;
            enable     <= '0;
            threshold  <= '0;
            in_service <= '0;
            irq        <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            for (int unsigned i = 0; i < N_SOURCES; i++) begin
                prio[i] <= '0;
            end
        end else begin
            src_q      <= src;
            irq        <= |eligible;
            rvalid     <= rd_en;
            rdata      <= rd_en ? rd_mux : '0;
            in_service <= (in_service & ~complete_mask) | claim_mask;
            if (wr_en && (addr == A_ENABLE)) begin
                enable <= wdata[N_SOURCES-1:0];
            end
            if (wr_en && (addr == A_THRESHOLD)) begin
                threshold <= wdata[PRIO_W-1:0];
            end
            for (int unsigned i = 0; i < N_SOURCES; i++) begin
                if (wr_en && (addr == ADDR_W'(32 + i))) begin
                    prio[i] <= wdata[PRIO_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_ladybird_irq_controller.sv
// Self-checking bench for ladybird_irq_controller: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_ladybird_irq_controller;

    localparam int N  = 8;
    localparam int PW = 3;
    localparam int AW = 6;

    logic          clk   = 1'b0;
    logic          nrst  = 1'b0;
    logic [N-1:0]  src   = '0;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [31:0]   wdata = '0;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          irq;

    ladybird_irq_controller #(
        .N_SOURCES(N),
        .PRIO_W   (PW),
        .ADDR_W   (AW)
    ) dut (
        .clk   (clk),
        .nrst  (nrst),
        .src   (src),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rvalid(rvalid),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural state as plain vectors/arrays.
    bit [N-1:0] m_sq, m_sqp, m_ep, m_en, m_mode, m_is, m_rise;
    int         m_prio [N];
    int         m_thr;
    int         m_w;
    int         m_a;
    bit         e_irq, e_rvalid;
    bit [31:0]  e_rdata;

    function automatic bit m_pend(int i);
        return m_mode[i] ? m_ep[i] : m_sq[i];
    endfunction

    // Scan priority levels from highest down, IDs ascending within a level.
    function automatic int m_winner();
        for (int p = (1 << PW) - 1; p > m_thr; p--)
            for (int id = 1; id <= N; id++)
                if (m_prio[id-1] == p && m_en[id-1] && !m_is[id-1] && m_pend(id-1))
                    return id;
        return 0;
    endfunction

    function automatic bit [31:0] m_read(int a);
        bit [31:0] v;
        v = 0;
        if (a == 0) begin
            for (int i = 0; i < N; i++) v[i] = m_pend(i);
        end else if (a == 1) v = 32'(m_en);
        else if (a == 2) v = 32'(m_thr);
        else if (a == 3) v = 32'(m_winner());
        else if (a == 4) v = 32'(m_mode);
        else if (a >= 32 && a < 32 + N) v = 32'(m_prio[a-32]);
        return v;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_sq = '0; m_sqp = '0; m_ep = '0; m_en = '0; m_mode = '0; m_is = '0;
            for (int i = 0; i < N; i++) m_prio[i] = 0;
            m_thr = 0;
            e_irq = 0; e_rvalid = 0; e_rdata = 0;
        end else begin
            m_a      = int'(addr);
            m_w      = m_winner();
            e_irq    = (m_w != 0);
            e_rvalid = req && !we;
            e_rdata  = (req && !we) ? m_read(m_a) : 0;
            if (req && !we && m_a == 3 && m_w != 0) begin
                m_is[m_w-1] = 1'b1;
                m_ep[m_w-1] = 1'b0;
            end
            m_rise = m_sq & ~m_sqp;
            m_ep   = m_ep | m_rise;
            if (req && we) begin
                if (m_a == 1) m_en = wdata[N-1:0];
                else if (m_a == 2) m_thr = int'(wdata[PW-1:0]);
                else if (m_a == 3) begin
                    if (wdata >= 1 && wdata <= N) m_is[int'(wdata)-1] = 1'b0;
                end
`ifdef LADYBIRD_IRQ_EDGE_EN
                else if (m_a == 4) m_mode = wdata[N-1:0];
`endif
                else if (m_a >= 32 && m_a < 32 + N) m_prio[m_a-32] = int'(wdata[PW-1:0]);
            end
            m_sqp = m_sq;
            m_sq  = src;
        end
    end

    always @(negedge clk) begin
        chk("irq", 32'(irq), 32'(e_irq));
        chk("rvalid", 32'(rvalid), 32'(e_rvalid));
        if (e_rvalid) chk("rdata", rdata, e_rdata);
        else if (!nrst) chk("rdata_reset", rdata, 32'h0);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = AW'(a); wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = AW'(a);
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("read_latency_rvalid", 32'(rvalid), 32'h1);
        d = rdata;
    endtask

    task automatic rand_traffic(input int n);
        repeat (n) begin
            if ($urandom_range(3) == 0) src = N'($urandom);
            if ($urandom_range(1) == 1) begin
                req = 1'b1;
                we  = 1'($urandom_range(1));
                case ($urandom_range(7))
                    0:       addr = AW'(0);
                    1:       addr = AW'(1);
                    2:       addr = AW'(2);
                    3, 4:    addr = AW'(3);
                    5:       addr = AW'(4);
                    6:       addr = AW'(32 + $urandom_range(N - 1));
                    default: addr = AW'($urandom_range(63));
                endcase
                wdata = ($urandom_range(1) == 1) ? 32'($urandom_range(10)) : $urandom;
            end else begin
                req = 1'b0;
                we  = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        we  = 1'b0;
    endtask

    logic [31:0] d;

    initial begin
        idle(3);
        nrst = 1'b1;
        idle(2);

        // Reset asserted in the middle of traffic.
        rand_traffic(200);
        nrst = 1'b0;
        src  = '0;
        #1;
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        idle(2);
        nrst = 1'b1;
        idle(1);
        rd(1, d);    chk("reset_enable", d, 32'h0);
        rd(2, d);    chk("reset_threshold", d, 32'h0);
        rd(4, d);    chk("reset_mode", d, 32'h0);
        rd(32, d);   chk("reset_prio0", d, 32'h0);

        // Priority and tie-break.
        wr(32 + 2, 5);
        wr(32 + 4, 5);
        wr(32 + 1, 3);
        wr(1, 32'h16);
        src = 8'h16;
        idle(3);
        rd(3, d);    chk("claim1", d, 32'd3);
        rd(3, d);    chk("claim2", d, 32'd5);
        rd(3, d);    chk("claim3", d, 32'd2);
        rd(3, d);    chk("claim4", d, 32'd0);
        wr(3, 3);
        wr(3, 5);
        wr(3, 2);

        // Threshold.
        wr(2, 5);
        idle(3);
        chk("thr5_irq", 32'(irq), 32'h0);
        rd(3, d);    chk("thr5_claim", d, 32'd0);
        wr(2, 4);
        chk("thr4_irq_t1", 32'(irq), 32'h0);
        idle(1);
        chk("thr4_irq_t2", 32'(irq), 32'h1);
        rd(3, d);    chk("thr4_claim", d, 32'd3);

        // Complete rules.
        wr(1, 32'h04);
        idle(2);
        chk("inservice_irq", 32'(irq), 32'h0);
        wr(3, 7);
        idle(2);
        chk("bad_complete_irq", 32'(irq), 32'h0);
        rd(3, d);    chk("bad_complete_claim", d, 32'd0);
        wr(3, 3);
        chk("complete_irq_t0", 32'(irq), 32'h0);
        idle(1);
        chk("complete_irq_t1", 32'(irq), 32'h1);
        rd(3, d);    chk("reclaim", d, 32'd3);
        wr(3, 3);

        // Source-to-irq latency.
        src = '0;
        wr(1, 32'h01);
        wr(32, 7);
        wr(2, 0);
        idle(3);
        chk("lat_irq_idle", 32'(irq), 32'h0);
        src = 8'h01;
        idle(1);
        chk("lat_irq_t1", 32'(irq), 32'h0);
        idle(1);
        chk("lat_irq_t2", 32'(irq), 32'h1);
        rd(3, d);    chk("lat_claim", d, 32'd1);
        wr(3, 1);

`ifdef LADYBIRD_IRQ_EDGE_EN
        // Edge mode: pulses latch pending, including one arriving during service.
        src = '0;
        wr(4, 1);
        idle(3);
        src = 8'h01;
        idle(1);
        src = '0;
        idle(4);
        rd(3, d);    chk("edge_claim1", d, 32'd1);
        src = 8'h01;
        idle(1);
        src = '0;
        idle(4);
        chk("edge_inservice_irq", 32'(irq), 32'h0);
        wr(3, 1);
        idle(2);
        chk("edge_repend_irq", 32'(irq), 32'h1);
        rd(3, d);    chk("edge_claim2", d, 32'd1);
        wr(3, 1);
        wr(4, 0);
`endif

        rand_traffic(3000);
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
